// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_tx between NUM_REQ byte sources.
// One byte is taken per grant; further grants wait for the transmitter's done pulse.
//
// Optional feature macro: UART_ARB_TIMEOUT_EN enables a WAIT_DONE watchdog that aborts
// a frame after TIMEOUT_CYCLES clocks without i_Tx_Done. When undefined, o_Timeout is
// tied low and no counter exists.
//
// Ports:
//   i_Clock, i_Rst_n       clock, async active-low reset
//   i_Req_Valid[NUM_REQ]   per-requester byte pending
//   i_Req_Byte[8*NUM_REQ]  requester k byte at [8k+7:8k]
//   o_Req_Ack[NUM_REQ]     one-hot, one-cycle "byte taken"
//   o_Tx_DV, o_Tx_Byte     start pulse and byte to uart_tx
//   i_Tx_Active, i_Tx_Done status from uart_tx
//   o_Grant_Id             index of last granted requester
//   o_Busy                 high from grant until done/timeout
//   o_Timeout              one-cycle pulse on watchdog abort
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                   i_Clock,
    input  logic                   i_Rst_n,
    input  logic [NUM_REQ-1:0]     i_Req_Valid,
    input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
    output logic [NUM_REQ-1:0]     o_Req_Ack,
    output logic                   o_Tx_DV,
    output logic [7:0]             o_Tx_Byte,
    input  logic                   i_Tx_Active,
    input  logic                   i_Tx_Done,
    output logic [2:0]             o_Grant_Id,
    output logic                   o_Busy,
    output logic                   o_Timeout
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned ID_W  = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win_id_c;
    logic             win_found_c;
    logic [7:0]       win_byte_c;
    logic             timeout_hit_c;

    // Rotating search: first valid index after the pointer, wrapping.
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx         = '0;
        win_id_c    = '0;
        win_found_c = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!win_found_c && i_Req_Valid[idx]) begin
                win_found_c = 1'b1;
                win_id_c    = idx;
            end
        end
    end

    // Byte mux for the winner.
    always_comb begin
        win_byte_c = 8'h00;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (IDX_W'(k) == win_id_c) begin
                win_byte_c = i_Req_Byte[8*k +: 8];
            end
        end
    end

    // Arbiter FSM with registered outputs.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state      <= IDLE;
            ptr        <= IDX_W'(NUM_REQ - 1);
            o_Req_Ack  <= '0;
            o_Tx_DV    <= 1'b0;
            o_Tx_Byte  <= 8'h00;
            o_Grant_Id <= '0;
            o_Busy     <= 1'b0;
        end else begin
            o_Req_Ack <= '0;
            o_Tx_DV   <= 1'b0;
            case (state)
                IDLE: begin
                    // i_Tx_Active guard keeps us off a frame still running after reset.
                    if (win_found_c && !i_Tx_Active) begin
                        o_Req_Ack  <= NUM_REQ'(1) << win_id_c;
                        o_Tx_DV    <= 1'b1;
                        o_Tx_Byte  <= win_byte_c;
                        o_Grant_Id <= ID_W'(win_id_c);
                        ptr        <= win_id_c;
                        o_Busy     <= 1'b1;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // Done here cannot belong to our frame; ignore it.
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (i_Tx_Done) begin
                        o_Busy <= 1'b0;
                        state  <= IDLE;
                    end else if (timeout_hit_c) begin
                        o_Busy <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) > 17) ? $clog2(TIMEOUT_CYCLES) : 17;

    logic [CNT_W-1:0] wd_cnt;

    assign timeout_hit_c = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: cleared on the way into WAIT_DONE, counts while there.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wd_cnt    <= '0;
            o_Timeout <= 1'b0;
        end else begin
            o_Timeout <= 1'b0;
            if (state == LAUNCH) begin
                wd_cnt <= '0;
            end else if (state == WAIT_DONE && !i_Tx_Done) begin
                if (timeout_hit_c) begin
                    o_Timeout <= 1'b1;
                end else begin
                    wd_cnt <= wd_cnt + CNT_W'(1);
                end
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit_c      = 1'b0;
    assign o_Timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner sequences,
// then randomized requesters and a uart_tx stand-in checked against a reference model.
module tb_uart_tx_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   valid = '0;
    logic [8*N-1:0] bytes = '0;
    logic           active = 1'b0;
    logic           done = 1'b0;
    logic [N-1:0]   ack;
    logic           dv;
    logic [7:0]     tx_byte;
    logic [2:0]     gid;
    logic           busy;
    logic           tmo;

    int checks = 0;
    int failures = 0;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .i_Clock     (clk),
        .i_Rst_n     (rst_n),
        .i_Req_Valid (valid),
        .i_Req_Byte  (bytes),
        .o_Req_Ack   (ack),
        .o_Tx_DV     (dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (active),
        .i_Tx_Done   (done),
        .o_Grant_Id  (gid),
        .o_Busy      (busy),
        .o_Timeout   (tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Complete a granted frame: launch cycle, one wait cycle, then done.
    task automatic finish_frame();
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("frame_end_busy", 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic [N-1:0]   valid;
        logic [8*N-1:0] bytes;
        logic           grant;
        logic [N-1:0]   ack;
        logic [7:0]     tx_byte;
        logic [2:0]     gid;
    } vec_t;

    vec_t tbl [10];

    // Reference model state (last winner, frame in flight, cycles since grant).
    int         m_last;
    bit         m_busy;
    int         m_age;
    logic [N-1:0] m_ack;
    logic       m_dv;
    logic [7:0] m_byte;
    logic [2:0] m_gid;
    logic       m_to;

    task automatic model_reset();
        m_last = N - 1; m_busy = 0; m_age = 0;
        m_ack = '0; m_dv = 0; m_byte = 8'h00; m_gid = 3'd0; m_to = 0;
    endtask

    // Winner = valid requester with the smallest circular distance past the last winner.
    task automatic model_edge(input logic [N-1:0] v, input logic [8*N-1:0] b,
                              input logic act, input logic dn);
        int best;
        int bestd;
        int d;
        m_ack = '0; m_dv = 0; m_to = 0;
        if (m_busy) begin
            if (m_age >= 1 && dn) begin
                m_busy = 0;
`ifdef UART_ARB_TIMEOUT_EN
            end else if (m_age == TO) begin
                m_busy = 0;
                m_to = 1;
`endif
            end
            m_age++;
        end else if (v != '0 && !act) begin
            best = 0;
            bestd = N;
            for (int k = 0; k < N; k++) begin
                d = (k - m_last - 1 + 2 * N) % N;
                if (v[k] && d < bestd) begin
                    bestd = d;
                    best = k;
                end
            end
            m_last = best;
            m_ack[best] = 1'b1;
            m_dv = 1;
            m_byte = b[8*best +: 8];
            m_gid = 3'(best);
            m_busy = 1;
            m_age = 0;
        end
    endtask

    initial begin
        int fr_rem;
        bit fr_on;
        bit hang;

        tbl[0] = '{4'b0100, 32'h44_A5_22_11, 1'b1, 4'b0100, 8'hA5, 3'd2};
        tbl[1] = '{4'b1111, 32'h44_33_22_11, 1'b1, 4'b1000, 8'h44, 3'd3};
        tbl[2] = '{4'b1111, 32'h44_33_22_11, 1'b1, 4'b0001, 8'h11, 3'd0};
        tbl[3] = '{4'b0101, 32'h44_33_22_11, 1'b1, 4'b0100, 8'h33, 3'd2};
        tbl[4] = '{4'b0101, 32'h44_33_22_11, 1'b1, 4'b0001, 8'h11, 3'd0};
        tbl[5] = '{4'b0001, 32'h44_33_22_11, 1'b1, 4'b0001, 8'h11, 3'd0};
        tbl[6] = '{4'b1010, 32'h44_33_22_11, 1'b1, 4'b0010, 8'h22, 3'd1};
        tbl[7] = '{4'b1010, 32'h44_33_22_11, 1'b1, 4'b1000, 8'h44, 3'd3};
        tbl[8] = '{4'b0010, 32'h44_33_22_11, 1'b1, 4'b0010, 8'h22, 3'd1};
        tbl[9] = '{4'b0000, 32'h44_33_22_11, 1'b0, 4'b0000, 8'h22, 3'd1};

        // Reset values
        #22;
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_dv", 64'(dv), 64'd0);
        check("rst_byte", 64'(tx_byte), 64'd0);
        check("rst_gid", 64'(gid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_timeout", 64'(tmo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: one full transaction per entry
        for (int i = 0; i < 10; i++) begin
            valid = tbl[i].valid;
            bytes = tbl[i].bytes;
            tick();
            check("tbl_ack", 64'(ack), 64'(tbl[i].ack));
            check("tbl_dv", 64'(dv), 64'(tbl[i].grant));
            check("tbl_byte", 64'(tx_byte), 64'(tbl[i].tx_byte));
            check("tbl_gid", 64'(gid), 64'(tbl[i].gid));
            check("tbl_busy", 64'(busy), 64'(tbl[i].grant));
            valid = '0;
            if (tbl[i].grant) begin
                tick();
                check("tbl_launch_dv", 64'(dv), 64'd0);
                check("tbl_launch_ack", 64'(ack), 64'd0);
                check("tbl_launch_busy", 64'(busy), 64'd1);
                tick();
                check("tbl_wait_busy", 64'(busy), 64'd1);
                done = 1'b1;
                tick();
                done = 1'b0;
                check("tbl_done_busy", 64'(busy), 64'd0);
                check("tbl_done_dv", 64'(dv), 64'd0);
            end
        end

        // Back-to-back, with a done during LAUNCH that must be ignored (pointer at 1)
        bytes = 32'h44_33_22_11;
        valid = 4'b0010;
        tick();
        check("b2b_first_dv", 64'(dv), 64'd1);
        check("b2b_first_ack", 64'(ack), 64'b0010);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("b2b_launch_done_ignored", 64'(busy), 64'd1);
        tick();
        check("b2b_wait_busy", 64'(busy), 64'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("b2b_done_busy", 64'(busy), 64'd0);
        check("b2b_done_no_dv", 64'(dv), 64'd0);
        tick();
        check("b2b_next_dv", 64'(dv), 64'd1);
        check("b2b_next_ack", 64'(ack), 64'b0010);
        valid = '0;
        finish_frame();

        // Active guard
        active = 1'b1;
        valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("guard_no_dv", 64'(dv), 64'd0);
            check("guard_no_busy", 64'(busy), 64'd0);
        end
        active = 1'b0;
        tick();
        check("guard_grant_dv", 64'(dv), 64'd1);
        check("guard_grant_ack", 64'(ack), 64'b0001);
        check("guard_grant_byte", 64'(tx_byte), 64'h11);
        valid = '0;
        finish_frame();

        // Reset mid-frame (pointer at 0, so requester 2 wins first)
        valid = 4'b0100;
        tick();
        check("midrst_gid", 64'(gid), 64'd2);
        valid = '0;
        tick();
        tick();
        check("midrst_busy_before", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ack", 64'(ack), 64'd0);
        check("midrst_dv", 64'(dv), 64'd0);
        check("midrst_byte", 64'(tx_byte), 64'd0);
        check("midrst_gid0", 64'(gid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round robin, all valid continuously: 0,1,2,3,0
        valid = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            tick();
            check("rr_dv", 64'(dv), 64'd1);
            check("rr_ack", 64'(ack), 64'(4'b0001 << (f % 4)));
            check("rr_gid", 64'(gid), 64'(f % 4));
            check("rr_byte", 64'(tx_byte), 64'(8'h11 * ((f % 4) + 1)));
            tick();
            check("rr_launch_ack", 64'(ack), 64'd0);
            check("rr_launch_dv", 64'(dv), 64'd0);
            tick();
            check("rr_wait_dv", 64'(dv), 64'd0);
            done = 1'b1;
            tick();
            done = 1'b0;
            check("rr_done_busy", 64'(busy), 64'd0);
        end
        valid = '0;
        finish_frame();

        // Watchdog (pointer at 0, requester 1 wins, requester 0 stays pending)
        valid = 4'b0011;
        tick();
        check("wd_grant_gid", 64'(gid), 64'd1);
`ifdef UART_ARB_TIMEOUT_EN
        for (int j = 1; j <= 16; j++) begin
            tick();
            check("wd_no_timeout_yet", 64'(tmo), 64'd0);
            check("wd_busy_held", 64'(busy), 64'd1);
        end
        tick();
        check("wd_timeout_pulse", 64'(tmo), 64'd1);
        check("wd_busy_cleared", 64'(busy), 64'd0);
        tick();
        check("wd_timeout_drop", 64'(tmo), 64'd0);
        check("wd_next_dv", 64'(dv), 64'd1);
        check("wd_next_gid", 64'(gid), 64'd0);
        valid = '0;
        finish_frame();
`else
        for (int j = 1; j <= 20; j++) begin
            tick();
            check("wd_off_busy_held", 64'(busy), 64'd1);
            check("wd_off_no_timeout", 64'(tmo), 64'd0);
        end
        valid = '0;
        done = 1'b1;
        tick();
        done = 1'b0;
        check("wd_off_done_busy", 64'(busy), 64'd0);
`endif

        // Randomized phase against the reference model
        @(negedge clk);
        rst_n = 1'b0;
        valid = '0;
        bytes = '0;
        active = 1'b0;
        done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        fr_on = 0;
        fr_rem = 0;
        hang = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            model_edge(valid, bytes, active, done);
            #1;
            check("rand_outputs", {32'(ack), 8'(dv), tx_byte, 5'(gid), 2'(busy), 1'(tmo)},
                                  {32'(m_ack), 8'(m_dv), m_byte, 5'(m_gid), 2'(m_busy), 1'(m_to)});
            // uart_tx stand-in
            done = 1'b0;
            if (m_dv) begin
`ifdef UART_ARB_TIMEOUT_EN
                hang = ($urandom_range(0, 9) == 0);
`endif
                fr_on = !hang;
                active = !hang;
                fr_rem = $urandom_range(2, 8);
            end else if (fr_on) begin
                fr_rem--;
                if (fr_rem == 0) begin
                    fr_on = 0;
                    active = 1'b0;
                    done = 1'b1;
                end
            end else begin
                active = ($urandom_range(0, 9) == 0);
            end
            // Requesters
            for (int k = 0; k < N; k++) begin
                if (m_ack[k]) begin
                    if ($urandom_range(0, 1) == 0) valid[k] = 1'b0;
                    else bytes[8*k +: 8] = 8'($urandom);
                end else if (valid[k]) begin
                    if ($urandom_range(0, 29) == 0) valid[k] = 1'b0;
                end else if ($urandom_range(0, 4) == 0) begin
                    valid[k] = 1'b1;
                    bytes[8*k +: 8] = 8'($urandom);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
